// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, sequencer states and
// the helper that sizes the latency counter.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // Counter must hold the longest latency value itself.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  function automatic logic is_mul_div(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: latched op/operands to a 64-bit {hi,lo} result.
// Signed division works on magnitudes so the INT_MIN / -1 case never overflows.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div_by_zero
);

  logic signed [63:0] w_a_s;
  logic signed [63:0] w_b_s;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_b_nz;
  logic [31:0]        w_qu;
  logic [31:0]        w_ru;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_qm;
  logic [31:0]        w_rm;
  logic [31:0]        w_qs;
  logic [31:0]        w_rs;

  assign w_a_s    = {{32{i_a[31]}}, i_a};
  assign w_b_s    = {{32{i_b[31]}}, i_b};
  assign w_prod_s = w_a_s * w_b_s;
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Zero divisor is replaced by one so the dividers never see it; result is discarded.
  assign w_b_nz = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_qu   = i_a / w_b_nz;
  assign w_ru   = i_a % w_b_nz;

  assign w_a_mag = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_b_mag = w_b_nz[31] ? (32'd0 - w_b_nz) : w_b_nz;
  assign w_qm    = w_a_mag / w_b_mag;
  assign w_rm    = w_a_mag % w_b_mag;
  assign w_qs    = (i_a[31] ^ w_b_nz[31]) ? (32'd0 - w_qm) : w_qm;
  assign w_rs    = i_a[31] ? (32'd0 - w_rm) : w_rm;

  always_comb begin
    o_res = 64'd0;
    case (i_op)
      MD_MULT:  o_res = w_prod_s;
      MD_MULTU: o_res = w_prod_u;
      MD_DIV:   o_res = {w_rs, w_qs};
      MD_DIVU:  o_res = {w_ru, w_qu};
      default:  o_res = 64'd0;
    endcase
  end

  assign o_div_by_zero = is_div(i_op) && (i_b == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative-timing MDU sequencer: owns HI/LO, latches operands on commit and
// writes the result after a fixed per-class latency.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  input  logic        md_use_D,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_accept;
  logic             w_start_mul_div;
  logic             w_done;
  logic [63:0]      w_res;
  logic             w_div_by_zero;

  mdu_arith u_arith (
    .i_op          (r_op),
    .i_a           (r_a),
    .i_b           (r_b),
    .o_res         (w_res),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_start_mul_div = start && is_mul_div(md_op);
  assign w_accept        = (r_state == ST_IDLE) && start && !req;
  assign w_done          = (r_state != ST_IDLE) && (r_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && is_mul_div(md_op)) begin
          w_state_nxt = is_div(md_op) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    stall_md = md_use_D && (busy || w_start_mul_div);
    md_rdata = rd_hi ? r_hi : r_lo;
    hi       = r_hi;
    lo       = r_lo;
  end

  // Operand latches, latency counter and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= 3'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (w_accept) begin
      case (md_op)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          r_op  <= md_op;
          r_a   <= rs_val;
          r_b   <= rt_val;
          r_cnt <= is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
        MD_MTHI: r_hi <= rs_val;
        MD_MTLO: r_lo <= rs_val;
        default: ;
      endcase
    end else if (r_state != ST_IDLE) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (w_done && !w_div_by_zero) begin
        {r_hi, r_lo} <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, req gating, stall and reset abort.
module tb_mdu_ctrl;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic        req;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hi;
  logic        md_use_D;
  logic [31:0] md_rdata;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .rd_hi    (rd_hi),
    .md_use_D (md_use_D),
    .md_rdata (md_rdata),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
  endtask

  task automatic quiet();
    start  = 1'b0;
    md_op  = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
  endtask

  // Call in cycle 0 with the op already driven; returns in cycle LAT+1.
  task automatic run_busy(input string tag, input int lat);
    step();
    quiet();
    for (int i = 1; i <= lat; i++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      step();
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    rd_hi    = 1'b0;
    md_use_D = 1'b0;
    quiet();
    step();
    step();
    reset = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst rdata", md_rdata, 32'd0);

    // MULT -3 * 5
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult nostall", {31'd0, stall_md}, 32'd0);
    run_busy("mult", MULT_LAT);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFF1);
    rd_hi = 1'b1;
    #1;
    check("mult rd hi", md_rdata, 32'hFFFF_FFFF);
    rd_hi = 1'b0;
    #1;
    check("mult rd lo", md_rdata, 32'hFFFF_FFF1);

    // DIVU 100 / 7
    issue(3'd4, 32'd100, 32'd7);
    run_busy("divu", DIV_LAT);
    check("divu lo", lo, 32'd14);
    check("divu hi", hi, 32'd2);

    // DIV -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    run_busy("div neg", DIV_LAT);
    check("div neg lo", lo, 32'hFFFF_FFFD);
    check("div neg hi", hi, 32'hFFFF_FFFF);

    // MTLO blocked by req, then committed
    issue(3'd6, 32'h0000_1234, 32'd0);
    req = 1'b1;
    step();
    quiet();
    req = 1'b0;
    check("mtlo req lo", lo, 32'hFFFF_FFFD);
    check("mtlo req busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h0000_1234, 32'd0);
    step();
    quiet();
    check("mtlo lo", lo, 32'h0000_1234);
    check("mtlo busy", {31'd0, busy}, 32'd0);

    // MULT blocked by req never goes busy
    issue(3'd1, 32'd2, 32'd3);
    req = 1'b1;
    step();
    quiet();
    req = 1'b0;
    check("mult req busy", {31'd0, busy}, 32'd0);
    check("mult req lo", lo, 32'h0000_1234);

    // Reserved op is a no-op
    issue(3'd7, 32'h5555_5555, 32'd1);
    step();
    quiet();
    check("rsvd busy", {31'd0, busy}, 32'd0);
    check("rsvd lo", lo, 32'h0000_1234);

    // MTHI does not stall a D-stage MD user
    md_use_D = 1'b1;
    issue(3'd5, 32'h0000_00AA, 32'd0);
    #1;
    check("mthi nostall", {31'd0, stall_md}, 32'd0);
    step();
    quiet();
    check("mthi hi", hi, 32'h0000_00AA);
    check("idle nostall", {31'd0, stall_md}, 32'd0);

    // MULTU max*max with stall tracking from cycle 0
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    check("multu stall c0", {31'd0, stall_md}, 32'd1);
    step();
    quiet();
    for (int i = 1; i <= int'(MULT_LAT); i++) begin
      check("multu stall", {31'd0, stall_md}, 32'd1);
      check("multu busy", {31'd0, busy}, 32'd1);
      step();
    end
    check("multu stall end", {31'd0, stall_md}, 32'd0);
    check("multu hi", hi, 32'hFFFF_FFFE);
    check("multu lo", lo, 32'h0000_0001);
    md_use_D = 1'b0;

    // Divide by zero leaves HI/LO intact
    issue(3'd5, 32'h0000_000A, 32'd0);
    step();
    issue(3'd6, 32'h0000_000B, 32'd0);
    step();
    issue(3'd3, 32'd5, 32'd0);
    run_busy("div0", DIV_LAT);
    check("div0 hi", hi, 32'h0000_000A);
    check("div0 lo", lo, 32'h0000_000B);

    // INT_MIN / -1
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("divmin", DIV_LAT);
    check("divmin lo", lo, 32'h8000_0000);
    check("divmin hi", hi, 32'h0000_0000);

    // Reset in busy cycle 3 aborts the MULT
    issue(3'd1, 32'd7, 32'd9);
    step();
    quiet();
    step();
    step();
    check("abort busy c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    for (int i = 0; i < int'(MULT_LAT); i++) step();
    check("abort late lo", lo, 32'd0);

    // MTHI while busy is ignored; follow-up op accepted in the first idle cycle
    issue(3'd1, 32'd2, 32'd3);
    step();
    $display("note: start driven while busy (deliberate protocol violation)");
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    check("ign busy c1", {31'd0, busy}, 32'd1);
    step();
    quiet();
    check("ign hi", hi, 32'd0);
    for (int i = 2; i <= int'(MULT_LAT); i++) begin
      check("ign busy", {31'd0, busy}, 32'd1);
      step();
    end
    check("ign idle", {31'd0, busy}, 32'd0);
    check("ign res hi", hi, 32'd0);
    check("ign res lo", lo, 32'd6);
    issue(3'd5, 32'h0000_0077, 32'd0);
    step();
    quiet();
    check("b2b hi", hi, 32'h0000_0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
